// File: rtl/xor_unit.sv
// -----------------------------------------------------------------------------
// xor_unit
//   Pipelined bitwise XOR of two equal-width operands with a valid/ready
//   stream on both sides. Each accepted pair yields the XOR result, its
//   reduction parity and an operands-equal flag, STAGES cycles later when the
//   pipeline is not stalled. A running XOR checksum folds in every delivered
//   result.
//
// Parameters
//   WIDTH   operand/result width in bits (1..64)
//   STAGES  register stages from acceptance to result visibility (1..4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   I1, I2     operands
//   in_valid   operand pair present
//   in_ready   unit accepts an operand pair this cycle
//   O          registered result I1 ^ I2
//   parity     reduction XOR of O
//   match      1 when the operands of this result were equal
//   out_valid  O/parity/match hold a result
//   out_ready  downstream accepts the result
//   acc_clr    synchronous clear of the checksum
//   acc        running XOR of all delivered results
// -----------------------------------------------------------------------------
module xor_unit #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] O,
    output logic             parity,
    output logic             match,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] acc
);

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] par_q, par_d;
    logic [STAGES-1:0] mat_q, mat_d;
    logic [WIDTH-1:0]  acc_q, acc_d;

    logic             advance;
    logic             deliver;
    logic [WIDTH-1:0] xor_in;

    // The whole pipeline moves as one; a stall only happens when the final
    // stage holds a result nobody takes.
    assign advance  = out_ready || !vld_q[STAGES-1];
    assign deliver  = vld_q[STAGES-1] && out_ready;
    assign in_ready = advance;
    assign xor_in   = I1 ^ I2;

    // Valid bits always shift on advance so bubbles keep their slot, but data,
    // parity and match only move behind a valid bit. That way the last stage
    // keeps showing the most recent result while out_valid is low.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        par_d  = par_q;
        mat_d  = mat_q;
        if (advance) begin
            // Stage 1: XOR and its derived flags.
            vld_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = xor_in;
                par_d[0]  = parity_of(xor_in);
                mat_d[0]  = is_zero(xor_in);
            end
            // Stages 2..STAGES: pure transport.
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    par_d[k]  = par_q[k-1];
                    mat_d[k]  = mat_q[k-1];
                end
            end
        end
    end

    // Clear happens before the fold, so a clear on a delivery cycle leaves
    // exactly the delivered value.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = deliver ? data_q[STAGES-1] : '0;
        end else if (deliver) begin
            acc_d = acc_q ^ data_q[STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= '0;
            par_q <= '0;
            mat_q <= '0;
            acc_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            par_q  <= par_d;
            mat_q  <= mat_d;
            acc_q  <= acc_d;
        end
    end

    assign O         = data_q[STAGES-1];
    assign parity    = par_q[STAGES-1];
    assign match     = mat_q[STAGES-1];
    assign out_valid = vld_q[STAGES-1];
    assign acc       = acc_q;

endmodule

// File: tb/tb_xor_unit.sv
module tb_xor_unit;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] I1, I2;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] O;
    logic         parity;
    logic         match;
    logic         out_valid;
    logic         out_ready;
    logic         acc_clr;
    logic [W-1:0] acc;

    xor_unit #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .I1       (I1),
        .I2       (I2),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .O        (O),
        .parity   (parity),
        .match    (match),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_clr  (acc_clr),
        .acc      (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-order queue of accepted results, each stamped
    // with the number of pipeline advances seen when it was accepted. A result
    // becomes visible once STAGES advances have passed since its acceptance.
    typedef struct {
        logic [W-1:0] data;
        int           t;
    } item_t;

    item_t        q[$];
    logic [W-1:0] del_log[$];
    int           adv_cnt;
    logic         exp_ov;
    logic [W-1:0] exp_o;
    logic         exp_par;
    logic         exp_mat;
    logic [W-1:0] exp_acc;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_ov  = 1'b0;
        exp_o   = '0;
        exp_par = 1'b0;
        exp_mat = 1'b0;
        exp_acc = '0;
    endtask

    task automatic refresh_visible();
        exp_ov = (q.size() > 0) && ((adv_cnt - q[0].t) >= S);
        if (exp_ov) begin
            exp_o   = q[0].data;
            exp_par = ^q[0].data;
            exp_mat = (q[0].data == '0);
        end
    endtask

    task automatic model_edge(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ordy, input logic clr);
        logic  adv;
        item_t it;
        adv = ordy || !exp_ov;
        if (exp_ov && ordy) begin
            it = q.pop_front();
            del_log.push_back(it.data);
            exp_acc = clr ? it.data : (exp_acc ^ it.data);
        end else if (clr) begin
            exp_acc = '0;
        end
        if (adv) begin
            if (iv) q.push_back('{data: a ^ b, t: adv_cnt});
            adv_cnt++;
        end
        refresh_visible();
    endtask

    task automatic check_outputs(input logic ordy);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
        chk("in_ready", {63'd0, in_ready}, {63'd0, (ordy || !exp_ov)});
        chk("O", {56'd0, O}, {56'd0, exp_o});
        chk("parity", {63'd0, parity}, {63'd0, exp_par});
        chk("match", {63'd0, match}, {63'd0, exp_mat});
        chk("acc", {56'd0, acc}, {56'd0, exp_acc});
    endtask

    // One clock cycle: drive, check pre-edge state, clock, update the model.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, input logic clr);
        in_valid  = iv;
        I1        = a;
        I2        = b;
        out_ready = ordy;
        acc_clr   = clr;
        #1;
        check_outputs(ordy);
        @(posedge clk);
        model_edge(iv, a, b, ordy, clr);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0);
    endtask

    logic [W-1:0] exp_stream[3];

    initial begin
        checks   = 0;
        failures = 0;
        adv_cnt  = 0;
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        I1        = '0;
        I2        = '0;
        out_ready = 1'b1;
        acc_clr   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_O", {56'd0, O}, 64'd0);
        chk("rst_parity", {63'd0, parity}, 64'd0);
        chk("rst_match", {63'd0, match}, 64'd0);
        chk("rst_acc", {56'd0, acc}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Equal operands.
        del_log.delete();
        step(1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0);
        idle(S + 1, 1'b1);
        chk("eq_count", del_log.size(), 64'd1);
        if (del_log.size() == 1) chk("eq_O", {56'd0, del_log[0]}, 64'h00);
        chk("eq_acc", {56'd0, acc}, 64'h00);

        // Streaming and checksum.
        step(1'b0, '0, '0, 1'b1, 1'b1);
        del_log.delete();
        exp_stream[0] = 8'hAA;
        exp_stream[1] = 8'hFF;
        exp_stream[2] = 8'h00;
        step(1'b1, 8'hA5, 8'h0F, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0);
        idle(S + 1, 1'b1);
        chk("stream_count", del_log.size(), 64'd3);
        for (int i = 0; i < 3 && i < del_log.size(); i++)
            chk("stream_O", {56'd0, del_log[i]}, {56'd0, exp_stream[i]});
        chk("stream_acc", {56'd0, acc}, 64'h55);

        // Checksum clear on a delivery cycle, then clear alone.
        step(1'b1, 8'h12, 8'h00, 1'b0, 1'b0);
        for (int n = 0; n < 10 && !exp_ov; n++) idle(1, 1'b0);
        chk("clr_pending_O", {56'd0, O}, 64'h12);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk("clr_fold_acc", {56'd0, acc}, 64'h12);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk("clr_alone_acc", {56'd0, acc}, 64'h00);

        // Backpressure: result pending, out_ready low, in_valid kept high.
        del_log.delete();
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h40, 8'h04, 1'b0, 1'b0);
        step(1'b1, 8'h81, 8'h18, 1'b0, 1'b0);
        for (int n = 0; n < 10 && !exp_ov; n++) step(1'b1, 8'hEE, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hEE, 8'h11, 1'b0, 1'b0);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_O_stable", {56'd0, O}, 64'h33);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        idle(8, 1'b1);
        chk("bp_count", del_log.size(), 64'd3);
        if (del_log.size() >= 3) begin
            chk("bp_order0", {56'd0, del_log[0]}, 64'h33);
            chk("bp_order1", {56'd0, del_log[1]}, 64'h44);
            chk("bp_order2", {56'd0, del_log[2]}, 64'h99);
        end

        // Bubbles: in_valid 1,0,1.
        step(1'b0, '0, '0, 1'b1, 1'b1);
        del_log.delete();
        step(1'b1, 8'hC3, 8'h01, 1'b1, 1'b0);
        step(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 8'h0F, 8'hF0, 1'b1, 1'b0);
        idle(S + 2, 1'b1);
        chk("bub_count", del_log.size(), 64'd2);
        chk("bub_acc", {56'd0, acc}, {56'd0, 8'hC2 ^ 8'hFF});

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(S + 2, 1'b1);

        // Reset with two results in flight.
        step(1'b1, 8'h5F, 8'h0A, 1'b1, 1'b0);
        step(1'b1, 8'h77, 8'h01, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_O", {56'd0, O}, 64'd0);
        chk("mrst_parity", {63'd0, parity}, 64'd0);
        chk("mrst_match", {63'd0, match}, 64'd0);
        chk("mrst_acc", {56'd0, acc}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(S + 2, 1'b1);
        step(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
        idle(S + 1, 1'b1);
        chk("post_rst_acc", {56'd0, acc}, 64'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
